// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches instructions from an 8-bit address space,
// presents each one to decode, applies conditional branch redirects and counts
// retired instructions. A halt request parks the sequencer until reset.
module pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  output logic [7:0]  pc_out,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero_flag,
  input  logic [63:0] immgen,
  input  logic        halt,
  output logic        taken,
  output logic [7:0]  retired
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StIssue,
    StHalt
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] retired_q, retired_d;
  logic       taken_q, taken_d;

  // Immediate is in halfword units; only the low byte of the byte offset
  // matters because pc arithmetic wraps modulo 256.
  logic [7:0] br_offset;
  logic [7:0] br_target;
  logic [7:0] seq_target;
  logic       br_taken;
  logic       unused_immgen;

  assign br_offset     = {immgen[6:0], 1'b0};
  assign br_target     = pc_q + br_offset;
  assign seq_target    = pc_q + 8'd4;
  assign br_taken      = branch & zero_flag;
  assign unused_immgen = ^immgen[63:7];

  // State, pc, retire counter and taken pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= 8'h00;
      retired_q <= 8'h00;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      taken_q   <= taken_d;
    end
  end

  // Next-state, datapath update and Moore outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    retired_d   = retired_q;
    taken_d     = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;

    case (state_q)
      StIdle: begin
        state_d = StFetch;
      end

      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_d = StIssue;
        end
      end

      StIssue: begin
        instr_valid = 1'b1;
        // Branch/halt inputs are only meaningful on the accepting cycle.
        if (!stall) begin
          retired_d = (retired_q == 8'hFF) ? retired_q : retired_q + 8'd1;
          if (br_taken) begin
            pc_d    = br_target;
            taken_d = 1'b1;
          end else begin
            pc_d = seq_target;
          end
          state_d = halt ? StHalt : StFetch;
        end
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign retired   = retired_q;
  assign taken     = taken_q;

`ifndef SYNTHESIS
  // Fetch request and decode presentation never overlap.
  req_valid_excl_a: assert property (@(posedge clk) disable iff (reset)
    !(imem_req && instr_valid));

  // A redirect is always followed by FETCH or HALT, so taken never repeats.
  taken_pulse_a: assert property (@(posedge clk) disable iff (reset)
    taken |=> !taken);
`endif

endmodule
